// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_pkg
// Brief    : Shared state encoding and bus widths for the boot ROM loader.
// Revision : 1.0
// ============================================================================
package rom_loader_pkg;

  localparam int c_rom_aw = 16;
  localparam int c_data_w = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ROM_REQ  = 3'd1,
    ST_ROM_WAIT = 3'd2,
    ST_RAM_REQ  = 3'd3,
    ST_RAM_WAIT = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERR      = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_if
// Brief    : ROM read port, RAM write port and boot status between loader and memories.
// Revision : 1.0
// ============================================================================
interface rom_loader_if
  import rom_loader_pkg::*;
#(
  parameter int RAM_AW = 16
);

  logic                rom_stb_o;
  logic [c_rom_aw-1:0] rom_addr_o;
  logic                rom_ack_i;
  logic [c_data_w-1:0] rom_data_i;
  logic                ram_stb_o;
  logic                ram_we_o;
  logic [RAM_AW-1:0]   ram_addr_o;
  logic [c_data_w-1:0] ram_data_o;
  logic                ram_ack_i;
  logic                done_o;
  logic                err_o;
  logic                cpu_rst_o;

  modport master (
    output rom_stb_o, rom_addr_o, ram_stb_o, ram_we_o, ram_addr_o, ram_data_o,
           done_o, err_o, cpu_rst_o,
    input  rom_ack_i, rom_data_i, ram_ack_i
  );

  modport slave (
    input  rom_stb_o, rom_addr_o, ram_stb_o, ram_we_o, ram_addr_o, ram_data_o,
           done_o, err_o, cpu_rst_o,
    output rom_ack_i, rom_data_i, ram_ack_i
  );

endinterface
`default_nettype wire

// File: rtl/rom_loader_ack_timer.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader_ack_timer
// Brief    : Saturating 8-bit acknowledge watchdog shared by both wait phases.
// Revision : 1.0
// ============================================================================
module rom_loader_ack_timer #(
  parameter int TIMEOUT = 15
) (
  input  wire  sys_clk,
  input  wire  sys_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] r_count;

  // Counts cycles since the strobe; expiry marks the last cycle an ack may land
  assign expired = (r_count >= 8'(TIMEOUT - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_count <= 8'd0;
    end else if (clr) begin
      r_count <= 8'd0;
    end else if (en && !expired) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Brief    : Copies WORDS words from boot ROM into RAM, then releases the core reset.
// Revision : 1.0
// ============================================================================
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [15:0] ROM_BASE = 16'h0000,
  parameter int          RAM_BASE = 0,
  parameter int          RAM_AW   = 16,
  parameter int          WORDS    = 7,
  parameter int          TIMEOUT  = 15
) (
  input wire           sys_clk,
  input wire           sys_rst,
  rom_loader_if.master bus
);

  localparam logic [15:0]       C_WORDS    = 16'(WORDS);
  localparam logic [RAM_AW-1:0] C_RAM_BASE = RAM_AW'(RAM_BASE);

  state_t              r_state;
  state_t              w_next;
  logic                w_rom_take;
  logic                w_ram_take;
  logic                w_last;
  logic                w_tmr_clr;
  logic                w_tmr_en;
  logic                w_tmr_exp;
  logic [15:0]         r_index;
  logic [c_rom_aw-1:0] r_rom_addr;
  logic [RAM_AW-1:0]   r_ram_addr;
  logic [c_data_w-1:0] r_ram_data;
  logic                r_rom_stb;
  logic                r_ram_stb;
  logic                r_done;
  logic                r_err;
  logic                r_cpu_rst;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_rom_take = 1'b0;
    w_ram_take = 1'b0;
    w_last     = ((r_index + 16'd1) == C_WORDS);
    unique case (r_state)
      ST_IDLE:     w_next = (C_WORDS == 16'd0) ? ST_DONE : ST_ROM_REQ;
      ST_ROM_REQ:  w_next = ST_ROM_WAIT;
      ST_ROM_WAIT: begin
        // An acknowledge in the expiry cycle still completes the read
        if (bus.rom_ack_i) begin
          w_rom_take = 1'b1;
          w_next     = ST_RAM_REQ;
        end else if (w_tmr_exp) begin
          w_next = ST_ERR;
        end
      end
      ST_RAM_REQ:  w_next = ST_RAM_WAIT;
      ST_RAM_WAIT: begin
        if (bus.ram_ack_i) begin
          w_ram_take = 1'b1;
          w_next     = w_last ? ST_DONE : ST_ROM_REQ;
        end else if (w_tmr_exp) begin
          w_next = ST_ERR;
        end
      end
      ST_DONE:     w_next = ST_DONE;
      ST_ERR:      w_next = ST_ERR;
      default:     w_next = ST_IDLE;
    endcase
    w_tmr_clr = (w_next == ST_ROM_REQ) || (w_next == ST_RAM_REQ);
    w_tmr_en  = (r_state == ST_ROM_REQ) || (r_state == ST_ROM_WAIT) ||
                (r_state == ST_RAM_REQ) || (r_state == ST_RAM_WAIT);
  end

  rom_loader_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (w_tmr_clr),
    .en      (w_tmr_en),
    .expired (w_tmr_exp)
  );

  // Strobes and status are decoded from the next state so every output is a flop
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rom_stb  <= 1'b0;
      r_ram_stb  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_cpu_rst  <= 1'b1;
      r_index    <= 16'd0;
      r_rom_addr <= ROM_BASE;
      r_ram_addr <= C_RAM_BASE;
      r_ram_data <= '0;
    end else begin
      r_rom_stb <= (w_next == ST_ROM_REQ);
      r_ram_stb <= (w_next == ST_RAM_REQ);
      r_done    <= (w_next == ST_DONE);
      r_err     <= (w_next == ST_ERR);
      r_cpu_rst <= (w_next != ST_DONE);
      if (w_rom_take) begin
        r_ram_data <= bus.rom_data_i;
      end
      if (w_ram_take) begin
        r_index <= r_index + 16'd1;
        if (!w_last) begin
          r_rom_addr <= r_rom_addr + 16'd1;
          r_ram_addr <= r_ram_addr + RAM_AW'(1);
        end
      end
    end
  end

  assign bus.rom_stb_o  = r_rom_stb;
  assign bus.rom_addr_o = r_rom_addr;
  assign bus.ram_stb_o  = r_ram_stb;
  assign bus.ram_we_o   = r_ram_stb;
  assign bus.ram_addr_o = r_ram_addr;
  assign bus.ram_data_o = r_ram_data;
  assign bus.done_o     = r_done;
  assign bus.err_o      = r_err;
  assign bus.cpu_rst_o  = r_cpu_rst;

endmodule
`default_nettype wire
